ft600_rx_drain: RTL and testbench
=================================

FT600_RX_DRAIN -- requirements
Module: ft600_rx_drain

Interface
REQ-001 SHALL have parameter RX_BUFFER, default 16: depth in bytes of the ft600_mode245 receive ring; power of two, minimum 4.
REQ-002 SHALL have parameter RX_BUFFER_WIDTH, default $clog2(RX_BUFFER): width of the ring pointer.
REQ-003 SHALL have port clk, input, 1: the only clock, the same clk that drives ft600_mode245.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port rx_buf, input, RX_BUFFER x 8: the receive ring contents written by ft600_mode245.
REQ-006 SHALL have port rx_buf_written, input, RX_BUFFER_WIDTH: the writer's next-write index, synchronous to clk.
REQ-007 SHALL have port out_data, output, 8: the drained byte.
REQ-008 SHALL have port out_valid, output, 1: out_data holds a byte.
REQ-009 SHALL have port out_ready, input, 1: the consumer accepts the byte this cycle.
REQ-010 SHALL have port level, output, RX_BUFFER_WIDTH: number of unread bytes still in the ring.
REQ-011 SHALL have port overflow, output, 1: sticky flag, present only when the overflow macro is defined.

Function
REQ-012 SHALL keep an internal read pointer rd_ptr; it wraps modulo RX_BUFFER (15 -> 0 at default depth).
REQ-013 SHALL compute level as (rx_buf_written - rd_ptr) mod RX_BUFFER; the ring is empty when level is 0.
REQ-014 SHALL use a two-state FSM: EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-015 SHALL, in EMPTY with level != 0 at edge t, register rx_buf[rd_ptr] into out_data, increment rd_ptr and enter HOLD; out_valid is 1 from t+1 (latency 1 cycle).
REQ-016 SHALL, in HOLD with out_ready=1 and level != 0, load the next byte in the same cycle and stay in HOLD (1 byte/cycle sustained).
REQ-017 SHALL, in HOLD with out_ready=1 and level=0, go to EMPTY.
REQ-018 SHALL, in HOLD with out_ready=0, keep out_data, out_valid and rd_ptr stable.
REQ-019 SHALL keep out_data unchanged while in EMPTY.
REQ-020 SHALL, when rx_buf_written changes in the same cycle as a load, use the pre-edge pointer values; the new byte is picked up on the following cycle.

Reset
REQ-021 SHALL, while rst=1, force rd_ptr=0, out_data=0, out_valid=0, FSM=EMPTY and overflow=0, asynchronously.
REQ-022 SHALL drop a byte in HOLD immediately when reset asserts mid-transfer; it is not replayed.
REQ-023 SHALL, on reset release, begin draining from index 0 at the first clk edge with rst=0.

Configuration
REQ-024 SHALL be controlled by the macro FT600_RX_DRAIN_OVERFLOW_EN.
- Defined: keep a registered copy of the previous rx_buf_written, delta = written - prev.
  - When level + delta > RX_BUFFER-1, set overflow=1 (sticky until reset) and set rd_ptr = rx_buf_written, discarding stale data.
  - A byte already in HOLD is still delivered.
- Undefined: no overflow port, no prev register; overruns go undetected.

Structure
REQ-025 SHALL place in the shared ft600 package: the RX_BUFFER default, the pointer-width function and the FSM state enum.
REQ-026 SHALL contain one sub-module, ft600_ring_level, which computes the modular level (and delta when FT600_RX_DRAIN_OVERFLOW_EN is defined).

Verification
REQ-027 Single byte: after reset, set rx_buf[0]=0xA5 and rx_buf_written 0->1 with out_ready=1 -> out_valid=1 with out_data=0xA5 exactly 1 cycle later, back to 0 the next cycle, level=0.
REQ-028 Streaming: writer advances 1 per 2 cycles with values 0,1,2... and out_ready=1 -> out_data sequence 0..31 in order, no gaps or duplicates, across two wrap-arounds of rd_ptr (15 -> 0).
REQ-029 Backpressure: 5 bytes written with out_ready=0 for 10 cycles -> out_data holds the first byte and level=4 throughout; after out_ready=1, 4 more bytes follow on consecutive cycles.
REQ-030 Overflow (macro on): with out_ready=0, advance the writer 16 slots past rd_ptr -> overflow=1 on the next cycle, rd_ptr=rx_buf_written, held byte still delivered, overflow stays 1 until rst.
REQ-031 Reset mid-operation: assert rst between clk edges while out_valid=1 and level=6 -> out_valid=0 and rd_ptr=0 immediately; after release, draining restarts at index 0.
REQ-032 Simultaneous: rx_buf_written increments in the same cycle as an out_ready handshake at level=0 -> FSM goes to EMPTY, then returns to HOLD on the next cycle with the new byte.

Source files
------------

// File: rtl/ft600_rx_drain_pkg.sv
// Shared definitions for the FT600 receive-ring drain: default ring depth,
// pointer-width helper and the drain FSM state encoding.
package ft600_rx_drain_pkg;

    // Default depth of the ft600_mode245 receive ring, in bytes.
    localparam int RX_BUFFER_DEFAULT = 16;

    // Drain FSM: EMPTY presents nothing, HOLD presents a byte on out_data.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } drain_state_e;

    // Width of a pointer that indexes a ring of the given depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ft600_rx_drain_if.sv
// Byte stream handshake between the ring drain (master) and its consumer (slave).
interface ft600_rx_drain_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ft600_rx_drain_level.sv
// ft600_ring_level: modular fill level of the receive ring.
// With FT600_RX_DRAIN_OVERFLOW_EN defined it also reports how far the writer
// moved since the previous cycle and whether that move lapped the reader.
module ft600_ring_level #(
    parameter int RX_BUFFER_WIDTH = 4
) (
    input  logic [RX_BUFFER_WIDTH-1:0] wr_ptr_i,
    input  logic [RX_BUFFER_WIDTH-1:0] rd_ptr_i,
    output logic [RX_BUFFER_WIDTH-1:0] level_o
`ifdef FT600_RX_DRAIN_OVERFLOW_EN
    ,
    input  logic [RX_BUFFER_WIDTH-1:0] prev_wr_i,
    output logic [RX_BUFFER_WIDTH-1:0] delta_o,
    output logic                       overrun_o
`endif
);

`ifdef FT600_RX_DRAIN_OVERFLOW_EN
    logic [RX_BUFFER_WIDTH-1:0] prev_level_s;
    logic [RX_BUFFER_WIDTH:0]   fill_sum_s;
`endif

    // Ring arithmetic: the depth is a power of two, so pointer wrap is free.
    always_comb begin
        level_o = wr_ptr_i - rd_ptr_i;
`ifdef FT600_RX_DRAIN_OVERFLOW_EN
        // Unread bytes before this cycle's writes plus the newly written
        // ones; a carry out of the pointer width means the ring was lapped.
        delta_o      = wr_ptr_i - prev_wr_i;
        prev_level_s = prev_wr_i - rd_ptr_i;
        fill_sum_s   = {1'b0, prev_level_s} + {1'b0, delta_o};
        overrun_o    = fill_sum_s[RX_BUFFER_WIDTH];
`endif
    end

endmodule

// File: rtl/ft600_rx_drain.sv
// ft600_rx_drain: drains bytes from the ft600_mode245 receive ring into a
// valid/ready byte stream, one byte per cycle sustained.
// Optional feature macro: FT600_RX_DRAIN_OVERFLOW_EN adds a sticky overflow
// port and resynchronises the read pointer when the writer laps it.
module ft600_rx_drain
    import ft600_rx_drain_pkg::*;
#(
    parameter int RX_BUFFER       = RX_BUFFER_DEFAULT,
    parameter int RX_BUFFER_WIDTH = ptr_width(RX_BUFFER)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [RX_BUFFER-1:0][7:0]       rx_buf,
    input  logic [RX_BUFFER_WIDTH-1:0]      rx_buf_written,
    ft600_rx_drain_if.master                out_if,
    output logic [RX_BUFFER_WIDTH-1:0]      level
`ifdef FT600_RX_DRAIN_OVERFLOW_EN
    ,
    output logic                            overflow
`endif
);

    localparam logic [RX_BUFFER_WIDTH-1:0] PTR_ZERO = {RX_BUFFER_WIDTH{1'b0}};
    localparam logic [RX_BUFFER_WIDTH-1:0] PTR_ONE  = {{(RX_BUFFER_WIDTH-1){1'b0}}, 1'b1};

    drain_state_e               state_q;
    logic [RX_BUFFER_WIDTH-1:0] rd_ptr_q;
    logic [7:0]                 data_q;
    logic [RX_BUFFER_WIDTH-1:0] level_s;
    logic                       load_s;
    logic                       overrun_s;

`ifdef FT600_RX_DRAIN_OVERFLOW_EN
    logic [RX_BUFFER_WIDTH-1:0] prev_wr_q;
    logic [RX_BUFFER_WIDTH-1:0] delta_s;
    logic                       overflow_q;
`endif

    ft600_ring_level #(
        .RX_BUFFER_WIDTH (RX_BUFFER_WIDTH)
    ) u_ring_level (
        .wr_ptr_i  (rx_buf_written),
        .rd_ptr_i  (rd_ptr_q),
        .level_o   (level_s)
`ifdef FT600_RX_DRAIN_OVERFLOW_EN
        ,
        .prev_wr_i (prev_wr_q),
        .delta_o   (delta_s),
        .overrun_o (overrun_s)
`endif
    );

`ifndef FT600_RX_DRAIN_OVERFLOW_EN
    assign overrun_s = 1'b0;
`endif

    // Decide whether a fresh byte is fetched from the ring this cycle.
    always_comb begin
        load_s = 1'b0;
        if (level_s != PTR_ZERO) begin
            if (state_q == ST_EMPTY) begin
                load_s = 1'b1;
            end else if (out_if.out_ready) begin
                load_s = 1'b1;
            end else begin
                load_s = 1'b0;
            end
        end else begin
            load_s = 1'b0;
        end
        // A lapped ring holds no trustworthy bytes; skip the fetch.
        load_s = load_s & ~overrun_s;
    end

    // Drain FSM with registered data, read pointer and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            rd_ptr_q <= PTR_ZERO;
            data_q   <= 8'h00;
        end else begin
            if (overrun_s) begin
                rd_ptr_q <= rx_buf_written;
            end else if (load_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                data_q   <= rx_buf[rd_ptr_q];
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end

            case (state_q)
                ST_EMPTY: begin
                    if (load_s) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_if.out_ready && !load_s) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef FT600_RX_DRAIN_OVERFLOW_EN
    // Track the writer one cycle behind and latch any overrun until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_wr_q  <= PTR_ZERO;
            overflow_q <= 1'b0;
        end else begin
            prev_wr_q <= rx_buf_written;
            if (overrun_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign overflow = overflow_q;
`endif

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = (state_q == ST_HOLD);
    assign level            = level_s;

endmodule

// File: tb/tb_ft600_rx_drain.sv
// Self-checking bench for ft600_rx_drain. A queue holds every byte the bench
// writer has put into the ring and the consumer has not yet accepted; each
// cycle the DUT outputs are compared with what that queue implies.
module tb_ft600_rx_drain;
    import ft600_rx_drain_pkg::*;

    localparam int N = 16;
    localparam int W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0][7:0]  rx_buf;
    logic [W-1:0]       wr;
    logic [W-1:0]       level;
`ifdef FT600_RX_DRAIN_OVERFLOW_EN
    logic               overflow;
`endif

    ft600_rx_drain_if bus ();

    ft600_rx_drain #(.RX_BUFFER(N), .RX_BUFFER_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_buf         (rx_buf),
        .rx_buf_written (wr),
        .out_if         (bus),
        .level          (level)
`ifdef FT600_RX_DRAIN_OVERFLOW_EN
        ,
        .overflow       (overflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0] q[$];     // written, not yet accepted by the consumer
    logic [7:0] got[$];   // bytes accepted by the consumer
    int         qprev = 0; // unaccepted bytes that existed at the last edge
    bit         model_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] v);
        rx_buf[wr] = v;
        wr = wr + 4'd1;
        q.push_back(v);
    endtask

    // After reset the reader restarts at index 0, so every slot below the
    // writer's index is unread again.
    task automatic resync();
        q.delete();
        for (int i = 0; i < int'(wr); i++) q.push_back(rx_buf[i]);
        qprev = 0;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    // Per-cycle comparison against the queue model.
    always @(negedge clk) begin
        if (model_en && !rst) begin
            chk("model_valid", 32'(bus.out_valid), 32'(qprev > 0));
            chk("model_level", 32'(level), 32'((q.size() - int'(bus.out_valid)) % N));
            if (bus.out_valid) begin
                chk("model_data", 32'(bus.out_data), 32'(q[0]));
                if (bus.out_ready) begin
                    got.push_back(bus.out_data);
                    void'(q.pop_front());
                end
            end
            qprev = q.size();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] first_after_rst;
        rst = 1'b1;
        wr = 4'd0;
        rx_buf = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'h00);
        chk("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        resync();
        model_en = 1'b1;

        // Single byte: latency one cycle, then back to empty.
        bus.out_ready = 1'b1;
        write_byte(8'hA5);
        step();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data", 32'(bus.out_data), 32'hA5);
        step();
        chk("single_valid_off", 32'(bus.out_valid), 32'd0);
        chk("single_level", 32'(level), 32'd0);

        // Streaming 0..31, one write every two cycles, across pointer wraps.
        got.delete();
        for (int v = 0; v < 32; v++) begin
            write_byte(8'(v));
            step();
            step();
        end
        drain(20, n);
        chk("stream_count", 32'(got.size()), 32'd32);
        for (int i = 0; i < 32 && i < got.size(); i++)
            chk("stream_seq", 32'(got[i]), 32'(i));

        // Backpressure: five bytes queued behind a stalled consumer.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            write_byte(8'h40 + 8'(i));
            step();
        end
        for (int c = 0; c < 10; c++) begin
            chk("bp_data", 32'(bus.out_data), 32'h40);
            chk("bp_level", 32'(level), 32'd4);
            step();
        end
        got.delete();
        bus.out_ready = 1'b1;
        drain(20, n);
        chk("bp_cycles", 32'(n), 32'd5);
        chk("bp_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk("bp_seq", 32'(got[i]), 32'h40 + 32'(i));

        // Writer advances on the same edge as a handshake at level 0.
        write_byte(8'h77);
        step();
        chk("simul_first", 32'(bus.out_data), 32'h77);
        step();
        write_byte(8'h78);
        chk("simul_empty", 32'(bus.out_valid), 32'd0);
        step();
        chk("simul_valid", 32'(bus.out_valid), 32'd1);
        chk("simul_data", 32'(bus.out_data), 32'h78);
        drain(10, n);

        // Reset between edges while a byte is held and six remain unread.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            write_byte(8'h60 + 8'(i));
            step();
        end
        chk("pre_rst_level", 32'(level), 32'd6);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'(wr));
        @(posedge clk);
        #1;
        rst = 1'b0;
        resync();
        first_after_rst = rx_buf[0];
        got.delete();
        bus.out_ready = 1'b1;
        drain(40, n);
        chk("post_rst_count", 32'(got.size()), 32'(wr));
        if (got.size() > 0) chk("post_rst_first", 32'(got[0]), 32'(first_after_rst));
        else chk("post_rst_first", 32'd0, 32'h100);

`ifdef FT600_RX_DRAIN_OVERFLOW_EN
        // Writer laps a stalled reader by a full ring.
        model_en = 1'b0;
        bus.out_ready = 1'b0;
        write_byte(8'hC0);
        step();
        chk("ovf_held", 32'(bus.out_data), 32'hC0);
        for (int i = 0; i < 15; i++) begin
            write_byte(8'hD0 + 8'(i));
            step();
        end
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        chk("ovf_full_level", 32'(level), 32'd15);
        write_byte(8'hDF);
        step();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd0);
        chk("ovf_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("ovf_hold_data", 32'(bus.out_data), 32'hC0);
        bus.out_ready = 1'b1;
        step();
        chk("ovf_after_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) step();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_quiet", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("ovf_rst", 32'(overflow), 32'd0);
        step();
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
